// File: rtl/pc_select_fsm.sv
// Multicycle FETCH/EXEC/TRAP control for the PC-select mux, with interrupt sync/latch and CSR strobes.
// Optional: define ILLEGAL_OP_TRAP_EN to trap on unsupported opcodes.
module pc_select_fsm #(
    parameter int INTR_SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ir,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic        intr,
    input  logic        csr_mie,
    output logic [2:0]  pcSource,
    output logic        pc_write,
    output logic        mem_rden1,
    output logic        mepc_we,
    output logic        mie_clr,
    output logic        mie_set,
    output logic        trap_busy
);

    typedef enum logic [1:0] {FETCH, EXEC, TRAP} state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t state, state_next;

    logic [INTR_SYNC_STAGES-1:0] intr_sync;
    logic intr_prev, intr_edge;
    logic pending, pending_clr;
    logic trap_ill, trap_ill_next;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_taken, is_mret, illegal;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign is_mret = (opcode == OP_SYSTEM) && (funct3 == 3'b000) && (ir[31:20] == 12'h302);

    logic unused_ir;
    assign unused_ir = ^{ir[19:15], ir[11:7]};

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = !br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = !br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

`ifdef ILLEGAL_OP_TRAP_EN
    always_comb begin
        illegal = 1'b1;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
            OP_STORE, OP_IMM, OP_OP, OP_SYSTEM: illegal = 1'b0;
            OP_BRANCH: illegal = (funct3[2:1] == 2'b01);
            default:   illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    // The edge flop watches the last synchroniser stage so a held level yields one pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            intr_sync <= '0;
            intr_prev <= 1'b0;
        end else begin
            intr_sync <= {intr_sync[INTR_SYNC_STAGES-2:0], intr};
            intr_prev <= intr_sync[INTR_SYNC_STAGES-1];
        end
    end

    assign intr_edge = intr_sync[INTR_SYNC_STAGES-1] & ~intr_prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= FETCH;
            pending  <= 1'b0;
            trap_ill <= 1'b0;
        end else begin
            state    <= state_next;
            pending  <= intr_edge | (pending & ~pending_clr);
            trap_ill <= trap_ill_next;
        end
    end

    always_comb begin
        state_next    = state;
        trap_ill_next = trap_ill;
        pending_clr   = 1'b0;
        pcSource      = 3'd0;
        pc_write      = 1'b0;
        mem_rden1     = 1'b0;
        mepc_we       = 1'b0;
        mie_clr       = 1'b0;
        mie_set       = 1'b0;
        trap_busy     = 1'b0;
        case (state)
            FETCH: begin
                mem_rden1  = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                pc_write = 1'b1;
                case (opcode)
                    OP_JAL:    pcSource = 3'd3;
                    OP_JALR:   pcSource = 3'd1;
                    OP_BRANCH: pcSource = br_taken ? 3'd2 : 3'd0;
                    OP_SYSTEM: begin
                        if (is_mret) begin
                            pcSource = 3'd5;
                            mie_set  = 1'b1;
                        end
                    end
                    default:   pcSource = 3'd0;
                endcase
                if (illegal) begin
                    pcSource      = 3'd0;
                    mie_set       = 1'b0;
                    state_next    = TRAP;
                    trap_ill_next = 1'b1;
                end else if (pending && csr_mie) begin
                    state_next    = TRAP;
                    trap_ill_next = 1'b0;
                end else begin
                    state_next    = FETCH;
                end
            end
            TRAP: begin
                pcSource    = 3'd4;
                pc_write    = 1'b1;
                mepc_we     = 1'b1;
                mie_clr     = 1'b1;
                trap_busy   = 1'b1;
                // An illegal-opcode trap leaves a latched interrupt for the next EXEC.
                pending_clr = !trap_ill;
                state_next  = FETCH;
            end
            default: state_next = FETCH;
        endcase
        if (RST) begin
            pcSource  = 3'd0;
            pc_write  = 1'b0;
            mem_rden1 = 1'b0;
            mepc_we   = 1'b0;
            mie_clr   = 1'b0;
            mie_set   = 1'b0;
            trap_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_select_fsm.sv
// Self-checking bench for pc_select_fsm: decode table, interrupt/reset sequences, randomized model compare.
module tb_pc_select_fsm;
    localparam int N = 2;
`ifdef ILLEGAL_OP_TRAP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif
    localparam int P_FETCH = 0, P_EXEC = 1, P_TRAP = 2;

    logic CLK = 1'b0;
    logic RST;
    logic [31:0] ir;
    logic br_eq, br_lt, br_ltu, intr, csr_mie;
    logic [2:0] pcSource;
    logic pc_write, mem_rden1, mepc_we, mie_clr, mie_set, trap_busy;

    pc_select_fsm #(.INTR_SYNC_STAGES(N)) dut (
        .CLK(CLK), .RST(RST), .ir(ir), .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
        .intr(intr), .csr_mie(csr_mie), .pcSource(pcSource), .pc_write(pc_write),
        .mem_rden1(mem_rden1), .mepc_we(mepc_we), .mie_clr(mie_clr), .mie_set(mie_set),
        .trap_busy(trap_busy)
    );

    always #5 CLK = ~CLK;

    int errors = 0, checks = 0;

    // Reference model: phase of the instruction cycle, interrupt sample history, pending flag.
    int m_phase;
    bit m_pend, m_ill;
    int k;
    bit samp [0:65535];

    function automatic bit s(int j);
        return (j < 1) ? 1'b0 : samp[j];
    endfunction

    function automatic bit ill_op(logic [31:0] i);
        logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        bit known = 1'b0;
        for (int j = 0; j < 10; j++) if (i[6:0] == ops[j]) known = 1'b1;
        if (i[6:0] == 7'h63 && i[14:13] == 2'b01) known = 1'b0;
        return ILL_EN && !known;
    endfunction

    function automatic logic [2:0] exp_pcs(logic [31:0] i, logic eq, logic lt, logic ltu);
        logic [7:0] tk;
        tk = {!ltu, ltu, !lt, lt, 1'b0, 1'b0, !eq, eq};
        if (i[6:0] == 7'h6F) return 3'd3;
        if (i[6:0] == 7'h67) return 3'd1;
        if (i[6:0] == 7'h63) return tk[i[14:12]] ? 3'd2 : 3'd0;
        if (i == 32'h30200073 || (i[6:0] == 7'h73 && i[14:12] == 3'b000 && i[31:20] == 12'h302))
            return 3'd5;
        return 3'd0;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_phase <= P_FETCH;
            m_pend  <= 1'b0;
            m_ill   <= 1'b0;
            k       <= 0;
        end else begin
            if (m_phase == P_FETCH) m_phase <= P_EXEC;
            else if (m_phase == P_EXEC) begin
                if (ill_op(ir)) begin m_phase <= P_TRAP; m_ill <= 1'b1; end
                else if (m_pend && csr_mie) begin m_phase <= P_TRAP; m_ill <= 1'b0; end
                else m_phase <= P_FETCH;
            end else m_phase <= P_FETCH;
            m_pend <= (s(k - N + 1) & ~s(k - N)) |
                      (m_pend & ~(m_phase == P_TRAP && !m_ill));
            samp[k + 1] <= intr;
            k <= k + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [8:0] o_last;
    int seen_trap;

    // Called at a negedge with inputs already driven; compares against the model, then advances.
    task automatic tick();
        logic [8:0] e;
        #1;
        e = '0;
        if (!RST) begin
            if (m_phase == P_FETCH) e = 9'b000_0100_00;
            else if (m_phase == P_EXEC)
                e = {exp_pcs(ir, br_eq, br_lt, br_ltu), 1'b1, 3'b000,
                     (!ill_op(ir) && exp_pcs(ir, br_eq, br_lt, br_ltu) == 3'd5), 1'b0};
            else e = {3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        end
        o_last = {pcSource, pc_write, mem_rden1, mepc_we, mie_clr, mie_set, trap_busy};
        chk("model_outs", {23'd0, o_last}, {23'd0, e});
        if (trap_busy) seen_trap++;
        @(negedge CLK);
    endtask

    logic [8:0] ex_out, tr_out;

    task automatic instr(input logic [31:0] i, output int traps);
        for (int j = 0; j < 4 && m_phase != P_FETCH; j++) tick();
        chk("align_fetch", m_phase, P_FETCH);
        seen_trap = 0;
        ir = i;
        tick();
        tick();
        ex_out = o_last;
        tr_out = '0;
        if (m_phase == P_TRAP) begin tick(); tr_out = o_last; end
        traps = seen_trap;
    endtask

    typedef struct {
        logic [31:0] ir;
        logic eq, lt, ltu;
        logic [2:0] pcs;
        logic mset;
        logic ill;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v [14];
        int t, tot, idx;
        logic [31:0] pool [14];
        v[0]  = '{32'h00208463, 1, 0, 0, 3'd2, 0, 0};
        v[1]  = '{32'h00208463, 0, 0, 0, 3'd0, 0, 0};
        v[2]  = '{32'h0020D463, 0, 0, 0, 3'd2, 0, 0};
        v[3]  = '{32'h0020E463, 0, 0, 1, 3'd2, 0, 0};
        v[4]  = '{32'h0020F463, 0, 0, 1, 3'd0, 0, 0};
        v[5]  = '{32'h00209463, 0, 0, 0, 3'd2, 0, 0};
        v[6]  = '{32'h0020A463, 1, 1, 1, 3'd0, 0, 1};
        v[7]  = '{32'h008000EF, 0, 0, 0, 3'd3, 0, 0};
        v[8]  = '{32'h000080E7, 0, 0, 0, 3'd1, 0, 0};
        v[9]  = '{32'h30200073, 0, 0, 0, 3'd5, 1, 0};
        v[10] = '{32'h00000073, 0, 0, 0, 3'd0, 0, 0};
        v[11] = '{32'h002081B3, 1, 1, 1, 3'd0, 0, 0};
        v[12] = '{32'h0000007F, 1, 1, 1, 3'd0, 0, 1};
        v[13] = '{32'h000000B7, 0, 0, 0, 3'd0, 0, 0};

        RST = 1'b1; ir = 32'h13; br_eq = 0; br_lt = 0; br_ltu = 0; intr = 0; csr_mie = 0;
        @(negedge CLK); @(negedge CLK);
        #1 chk("reset_outs", {pcSource, pc_write, mem_rden1, mepc_we, mie_clr, mie_set, trap_busy}, 0);
        @(negedge CLK);
        RST = 1'b0;

        // Decode table, csr_mie=0 and no interrupt: only illegal opcodes may trap.
        for (int n = 0; n < 14; n++) begin
            br_eq = v[n].eq; br_lt = v[n].lt; br_ltu = v[n].ltu;
            instr(v[n].ir, t);
            chk($sformatf("pcs_%0d", n), ex_out[8:6], v[n].pcs);
            chk($sformatf("pcwr_%0d", n), ex_out[5], 1);
            chk($sformatf("mset_%0d", n), ex_out[1], v[n].mset);
            chk($sformatf("trap_%0d", n), t, ILL_EN & v[n].ill);
            if (t != 0) chk($sformatf("illtrap_outs_%0d", n), tr_out, 9'b100_1011_01);
        end

        // Interrupt with MIE set; held-high level must trap once.
        csr_mie = 1; br_eq = 0; br_lt = 0; br_ltu = 0;
        instr(32'h002081B3, t); instr(32'h002081B3, t);
        intr = 1; tot = 0; idx = -1;
        for (int n = 0; n < 12; n++) begin
            instr(32'h002081B3, t);
            if (t != 0 && idx < 0) begin
                idx = n;
                chk("intr_trap_outs", tr_out, 9'b100_1011_01);
            end
            tot += t;
        end
        chk("intr_trap_instr", idx, 1);
        chk("held_high_one_trap", tot, 1);

        // Reset pulsed in the middle of a TRAP cycle.
        intr = 0;
        for (int n = 0; n < 3; n++) instr(32'h002081B3, t);
        intr = 1;
        instr(32'h002081B3, t);
        ir = 32'h002081B3;
        tick(); tick();
        #1 chk("pre_reset_in_trap", trap_busy, 1);
        RST = 1'b1;
        #1 chk("reset_mid_trap", {pcSource, pc_write, mem_rden1, mepc_we, mie_clr, mie_set, trap_busy}, 0);
        intr = 0;
        @(negedge CLK);
        RST = 1'b0;
        #1 chk("post_reset_fetch", {mem_rden1, pc_write, pcSource}, 5'b10000);
        tot = 0;
        for (int n = 0; n < 6; n++) begin instr(32'h002081B3, t); tot += t; end
        chk("post_reset_no_trap", tot, 0);

        // Masked interrupt stays pending until MIE is raised.
        csr_mie = 0;
        intr = 1; tot = 0;
        for (int n = 0; n < 10; n++) begin instr(32'h002081B3, t); tot += t; end
        chk("masked_no_trap", tot, 0);
        csr_mie = 1;
        instr(32'h002081B3, t);
        chk("unmask_trap", t, 1);

        // mret with a pending interrupt: mret runs, trap follows the next EXEC.
        csr_mie = 0; intr = 0;
        for (int n = 0; n < 2; n++) instr(32'h002081B3, t);
        intr = 1;
        for (int n = 0; n < 4; n++) instr(32'h002081B3, t);
        instr(32'h30200073, t);
        chk("mret_pcs", ex_out[8:6], 5);
        chk("mret_mie_set", ex_out[1], 1);
        chk("mret_no_trap", t, 0);
        csr_mie = 1;
        instr(32'h002081B3, t);
        chk("after_mret_trap", t, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 14; n++) pool[n] = v[n].ir;
        for (int n = 0; n < 400; n++) begin
            br_eq = 1'($urandom); br_lt = 1'($urandom); br_ltu = 1'($urandom);
            csr_mie = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) intr = ~intr;
            if ($urandom_range(0, 7) == 0) instr($urandom, t);
            else instr(pool[$urandom_range(0, 13)], t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_select_fsm.md
Name: pc_select_fsm

Overview:
- Multicycle control FSM that produces the program-counter mux select and PC write strobe for the core's PC-select mux.
- Sequences FETCH/EXEC/TRAP.
- Resolves branch conditions.
- Synchronises and latches the external interrupt.
- Drives the mepc capture and mie set/clear strobes toward the CSR file.

Parameters:
- INTR_SYNC_STAGES, 2, number of flip-flops synchronising the external intr input (min 2).

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- ir  input  32  current instruction register contents
- br_eq  input  1  rs1 == rs2
- br_lt  input  1  rs1 < rs2, signed
- br_ltu  input  1  rs1 < rs2, unsigned
- intr  input  1  external interrupt request, asynchronous level
- csr_mie  input  1  current mstatus.MIE from CSR file
- pcSource  output  3  PC mux select: 0 pc+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc
- pc_write  output  1  PC register load enable
- mem_rden1  output  1  instruction memory read enable
- mepc_we  output  1  CSR file captures current PC into mepc
- mie_clr  output  1  CSR file clears MIE (trap entry)
- mie_set  output  1  CSR file sets MIE (mret)
- trap_busy  output  1  high while in TRAP state

Behaviour:
- Reset (async, RST=1):
  - State = FETCH.
  - Synchroniser flops, edge-detect flop and pending latch = 0.
  - All outputs 0 while RST is high; an in-progress TRAP is abandoned with no mepc_we pulse.
- State encoding: FETCH, EXEC, TRAP. Outputs are combinational from state, ir and branch flags.
- FETCH:
  - mem_rden1=1, pc_write=0, pcSource=0.
  - Next state is always EXEC.
- EXEC: pc_write=1 and pcSource from ir[6:0]:
  - 1101111 (JAL) -> 3
  - 1100111 (JALR) -> 1
  - 1100011 (BRANCH) -> 2 if taken, else 0. Taken by ir[14:12]:
    - 000: br_eq
    - 001: !br_eq
    - 100: br_lt
    - 101: !br_lt
    - 110: br_ltu
    - 111: !br_ltu
    - 010/011: never taken
  - 1110011 with ir[14:12]=000 and ir[31:20]=12'h302 (mret) -> 5, plus mie_set=1 for that cycle.
  - All other opcodes -> 0.
  - Next state: TRAP if (pending & csr_mie), else FETCH. csr_mie is the value present during the EXEC cycle.
- TRAP (exactly one cycle):
  - pcSource=4, pc_write=1, mepc_we=1, mie_clr=1, trap_busy=1.
  - The PC already holds the address of the next instruction, so mepc receives the post-EXEC PC, including a jump/branch target.
  - Pending latch clears on exit.
  - Next state is FETCH.
- Interrupt path:
  - intr passes through INTR_SYNC_STAGES flops; the edge detector fires on the synced 0->1 transition.
  - pending sets on a detected edge and clears only on TRAP.
  - An edge arriving in the TRAP cycle itself is retained: set wins over clear.
  - A held-high intr produces one trap only.
- Masking: pending stays latched while csr_mie=0. The trap is taken at the first EXEC in which csr_mie=1.
- mret with pending interrupt: mret executes (pcSource=5, mie_set). No trap that EXEC, because the sampled csr_mie=0. The trap is taken at the following EXEC.
- Latency:
  - Non-trap instruction: 2 cycles.
  - Trapped instruction: 3 cycles.
  - intr edge to pending: INTR_SYNC_STAGES+1 cycles.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: in EXEC, an opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM}, or a BRANCH with funct3 010/011:
  - forces pcSource=0 and pc_write=1;
  - next state is TRAP regardless of csr_mie and pending;
  - pending is not cleared by this TRAP.
- Undefined: illegal opcodes behave as pcSource=0, and no trap is generated.

Test Plan:
- Reset: RST pulsed mid-TRAP -> all outputs 0 immediately. After release, first cycle is FETCH with mem_rden1=1, pc_write=0.
- BEQ ir=32'h00208463 with br_eq=1 -> EXEC pcSource=2. Same with br_eq=0 -> pcSource=0. Same with funct3=101, br_lt=0 -> pcSource=2.
- JAL 32'h008000EF -> pcSource=3. JALR 32'h000080E7 -> pcSource=1. Both pc_write=1, 2-cycle cadence.
- intr rises, csr_mie=1, ADD in flight -> within INTR_SYNC_STAGES+1 cycles pending=1. Next EXEC is followed by a TRAP cycle with pcSource=4, mepc_we=1, mie_clr=1. Held-high intr yields no second trap.
- intr edge with csr_mie=0 -> no trap for 10 instructions. Raise csr_mie -> trap after the next EXEC. mret 32'h30200073 with pending -> pcSource=5, mie_set=1, then trap after the following EXEC.
- With ILLEGAL_OP_TRAP_EN, ir=32'h0000007F -> EXEC pcSource=0, then TRAP pcSource=4 with csr_mie=0. Without the macro -> FETCH follows, no TRAP.
